// File: rtl/axis_cmd_arbiter_pkg.sv
// Shared constants for the command arbiter: command word width, reset polarity
// and the round-robin index helper.
package axis_cmd_arbiter_pkg;

    localparam int CMD_W = 32;

    // Reset is synchronous; the arbiter and the downstream reg_maps reset when rst equals this.
    localparam logic RST_ASSERTED = 1'b0;

    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 8;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/axis_cmd_arbiter_rr_arbiter.sv
// Round-robin winner search: the first requester after last_grant, wrapping
// from N_REQ-1 back to 0.
module rr_arbiter
    import axis_cmd_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GW    = $clog2(N_REQ)
)
(
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    last_grant,
    output logic             any,
    output logic [GW-1:0]    winner
);

    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!any && req[GW'(rr_index(int'(last_grant), k, N_REQ))]) begin
                any    = 1'b1;
                winner = GW'(rr_index(int'(last_grant), k, N_REQ));
            end
        end
    end

endmodule

// File: rtl/axis_cmd_arbiter.sv
// Merges N_REQ address/data command pair streams onto the single reg_map
// daisy-chain head; a grant is held until both words of the pair have passed.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no pair in flight; grant a new requester when en is high
// ST_ADDR | granted requester's address word is being accepted
// ST_DATA | granted requester's data word is being accepted (may stall)
module axis_cmd_arbiter
    import axis_cmd_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GW    = $clog2(N_REQ)
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [CMD_W*N_REQ-1:0] req_TDATA,
    input  logic [N_REQ-1:0]       req_TVALID,
    output logic [N_REQ-1:0]       req_TREADY,
    output logic [CMD_W-1:0]       cmd_out_TDATA,
    output logic                   cmd_out_TVALID,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
);

    if (N_REQ < MIN_REQ || N_REQ > MAX_REQ) begin : g_bad_n_req
        $error("axis_cmd_arbiter: N_REQ out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   grant_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   last_grant_nxt;
    logic            rr_any;
    logic [GW-1:0]   rr_winner;
    logic            beat_acc;
    logic [CMD_W-1:0] req_word [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_word[i] = req_TDATA[CMD_W*i +: CMD_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_rr (
        .req        (req_TVALID),
        .last_grant (last_grant),
        .any        (rr_any),
        .winner     (rr_winner)
    );

    assign busy = (state != ST_IDLE);

    // Ready decodes only registered state so no path exists from TVALID to TREADY.
    always_comb begin
        req_TREADY = '0;
        if (busy) begin
            req_TREADY[grant_id] = 1'b1;
        end
    end

    assign beat_acc = busy && req_TVALID[grant_id];

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        last_grant_nxt = last_grant;
        case (state)
            ST_IDLE: begin
                if (en && rr_any) begin
                    state_nxt = ST_ADDR;
                    grant_nxt = rr_winner;
                end
            end
            ST_ADDR: begin
                if (beat_acc) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // en is deliberately ignored here: a started pair always finishes.
                if (beat_acc) begin
                    state_nxt      = ST_IDLE;
                    last_grant_nxt = grant_id;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ASSERTED) begin
            state          <= ST_IDLE;
            grant_id       <= '0;
            last_grant     <= GW'(N_REQ - 1);
            cmd_out_TVALID <= 1'b0;
            cmd_out_TDATA  <= '0;
        end else begin
            state          <= state_nxt;
            grant_id       <= grant_nxt;
            last_grant     <= last_grant_nxt;
            cmd_out_TVALID <= beat_acc;
            if (beat_acc) begin
                cmd_out_TDATA <= req_word[grant_id];
            end
        end
    end

endmodule
